// File: rtl/alu_controller.sv
// Multi-cycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback
// and raises one-cycle pulses for illegal opcodes and memory-handshake timeouts.
module alu_controller #(
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] ALUControl,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       illegal_op,
  output logic       mem_err
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [7:0] TIMEOUT_V = 8'(TIMEOUT_CYC);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       wait_st;
  logic       timeout;
  logic       illegal;
  logic       f3_ok;
  logic [2:0] exec_alu;

  always_comb begin
    wait_st = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    timeout = wait_st && !mem_ready && (cnt_q == TIMEOUT_V);
    f3_ok   = (funct3 == 3'b000) || (funct3 == 3'b110) || (funct3 == 3'b111);
  end

  always_comb begin
    illegal = 1'b0;
    case (op)
      OP_LOAD, OP_STORE, OP_JAL: illegal = 1'b0;
      OP_R:    illegal = !f3_ok || (funct7b5 && (funct3 != 3'b000));
      OP_I:    illegal = !f3_ok;
      OP_BR:   illegal = (funct3 != 3'b000);
      default: illegal = 1'b1;
    endcase
  end

  // Only EXECR honours funct7b5; for I-type bit 30 is part of the immediate.
  always_comb begin
    exec_alu = 3'b000;
    case (funct3)
      3'b000:  exec_alu = (state_q == S_EXECR && funct7b5) ? 3'b001 : 3'b000;
      3'b110:  exec_alu = 3'b011;
      3'b111:  exec_alu = 3'b010;
      default: exec_alu = 3'b000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = (mem_ready && !timeout) ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (illegal) state_d = S_FETCH;
        else begin
          case (op)
            OP_LOAD, OP_STORE: state_d = S_MEMADR;
            OP_R:              state_d = S_EXECR;
            OP_I:              state_d = S_EXECI;
            OP_BR:             state_d = S_BEQ;
            OP_JAL:            state_d = S_JAL;
            default:           state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = timeout ? S_FETCH : (mem_ready ? S_MEMWB : S_MEMREAD);
      S_MEMWRITE: state_d = (timeout || mem_ready) ? S_FETCH : S_MEMWRITE;
      S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
      S_ALUWB, S_MEMWB, S_BEQ: state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // A timeout re-enters FETCH even from FETCH, so it must clear the count too.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) || timeout) cnt_d = 8'd0;
    else if (wait_st && !mem_ready)      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    ALUControl = 3'b000;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ImmSrc     = 2'b00;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    illegal_op = 1'b0;
    mem_err    = 1'b0;
    if (rst_n) begin
      mem_err = timeout;
      case (state_q)
        S_FETCH: begin
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          IRWrite   = mem_ready;
          PCWrite   = mem_ready;
        end
        S_DECODE: begin
          ALUSrcA    = 2'b01;
          ALUSrcB    = 2'b01;
          ImmSrc     = 2'b10;
          illegal_op = illegal;
        end
        S_MEMADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ImmSrc  = (op == OP_LOAD) ? 2'b00 : 2'b01;
        end
        S_MEMREAD:  AdrSrc = 1'b1;
        S_MEMWRITE: begin
          AdrSrc   = 1'b1;
          MemWrite = !timeout;
        end
        S_MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
        end
        S_EXECR: begin
          ALUSrcA    = 2'b10;
          ALUControl = exec_alu;
        end
        S_EXECI: begin
          ALUSrcA    = 2'b10;
          ALUSrcB    = 2'b01;
          ALUControl = exec_alu;
        end
        S_ALUWB: RegWrite = 1'b1;
        S_BEQ: begin
          ALUSrcA    = 2'b10;
          ALUControl = 3'b001;
          PCWrite    = zero;
        end
        S_JAL: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
          ImmSrc  = 2'b11;
          PCWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_controller.md
ALU_CONTROLLER -- requirements
Module: alu_controller

Interface
REQ-001 TIMEOUT_CYC, default 15, max cycles waited on mem_ready in FETCH/MEMREAD/MEMWRITE; legal range 1..255.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 op  input  7  instr[6:0]; valid from DECODE onward.
REQ-005 funct3  input  3  instr[14:12].
REQ-006 funct7b5  input  1  instr[30].
REQ-007 zero  input  1  ALU result == 0.
REQ-008 mem_ready  input  1  memory access completes this cycle.
REQ-009 ALUControl  output  3  000 add, 001 sub, 010 and, 011 or.
REQ-010 ALUSrcA  output  2  00 PC, 01 OldPC, 10 rs1.
REQ-011 ALUSrcB  output  2  00 rs2, 01 imm, 10 const 4.
REQ-012 ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult.
REQ-013 ImmSrc  output  2  00 I, 01 S, 10 B, 11 J.
REQ-014 AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite  output  1 each  address select (0 PC, 1 ALUOut) / write enables.
REQ-015 illegal_op, mem_err  output  1 each  one-cycle error pulses.

Function
REQ-016 Registered state: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
REQ-017 Transitions: FETCH->DECODE on mem_ready; MEMADR->MEMREAD (op 0000011) else MEMWRITE; MEMREAD->MEMWB on mem_ready; MEMWRITE->FETCH on mem_ready; EXECR/EXECI/JAL->ALUWB; ALUWB/MEMWB/BEQ->FETCH.
REQ-018 DECODE: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BEQ, 1101111->JAL.
REQ-019 DECODE illegal (illegal_op=1 that cycle, next FETCH, no writes): unlisted op; R/I-type with funct3 not in {000,110,111}; R-type with funct7b5=1 and funct3!=000; branch with funct3!=000.
REQ-020 Outputs combinational from state, op, funct3, funct7b5, zero, mem_ready, counter; any output not listed for a state is 0.
REQ-021 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUControl=000, ResultSrc=10, IRWrite=PCWrite=mem_ready; PC+4 exactly once per instruction.
REQ-022 DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=10, ALUControl=000 (branch target precompute).
REQ-023 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUControl=000; ImmSrc=00 load, 01 store.
REQ-024 MEMREAD: AdrSrc=1. MEMWRITE: AdrSrc=1, MemWrite=1 held until completion/timeout. MEMWB: ResultSrc=01, RegWrite=1.
REQ-025 EXECR: ALUSrcA=10, ALUSrcB=00. EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=00. ALUWB: ResultSrc=00, RegWrite=1.
REQ-026 EXECR/EXECI ALUControl: funct3 000 -> 001 if EXECR and funct7b5, else 000; 110 -> 011; 111 -> 010.
REQ-027 BEQ: ALUSrcA=10, ALUSrcB=00, ALUControl=001, ResultSrc=00, PCWrite=zero.
REQ-028 JAL: ALUSrcA=01, ALUSrcB=10, ALUControl=000, ResultSrc=00, ImmSrc=11, PCWrite=1.
REQ-029 Wait counter, 8-bit: cleared on entry to FETCH/MEMREAD/MEMWRITE; +1 per cycle in those states with mem_ready=0; never exceeds TIMEOUT_CYC.
REQ-030 Timeout: counter==TIMEOUT_CYC and mem_ready=0 -> mem_err=1 that cycle, IRWrite/PCWrite/MemWrite=0, next FETCH, counter cleared.
REQ-031 mem_ready=1 on the timeout cycle is normal completion: no mem_err.

Reset
REQ-032 rst_n=0 at clk edge: state=FETCH, counter=0; overrides any transition, including mid-MEMWRITE.
REQ-033 While rst_n=0: all enables and error pulses 0, selects 00, ALUControl 000.
REQ-034 First cycle after release behaves as FETCH per REQ-021.

Verification
REQ-035 rst_n=0 2 cycles, mem_ready=1 -> all enables 0; release -> first cycle IRWrite=PCWrite=1.
REQ-036 op=0110011, funct3=000, funct7b5=1, mem_ready=1 -> FETCH,DECODE,EXECR,ALUWB; ALUControl=001 in EXECR; RegWrite=1 only in ALUWB; funct7b5=0 -> 000.
REQ-037 lw (op=0000011), mem_ready=0 for 3 MEMREAD cycles -> MEMREAD held 4 cycles; then MEMWB, ResultSrc=01, RegWrite=1; no mem_err.
REQ-038 beq (op=1100011, funct3=000): zero=1 -> PCWrite=1 in BEQ; zero=0 -> PCWrite=0; funct3=001 -> illegal_op pulse in DECODE, back to FETCH.
REQ-039 sw, mem_ready=0 held, TIMEOUT_CYC=15 -> MemWrite=1 for 15 cycles, 16th cycle mem_err=1 with MemWrite=0, then FETCH; mem_ready=1 on 16th -> MemWrite=1, no mem_err.
REQ-040 op=0000000 -> illegal_op=1 for one DECODE cycle, no RegWrite/MemWrite, next state FETCH.
